// File: rtl/cosim_commit_queue.sv
// cosim_commit_queue: commit-trace buffer between the core's commit stage and
// the co-simulation checker. Packs up to COMMIT_WIDTH retired instructions and
// one trap event per cycle, in program order, into a circular queue and
// presents them one entry per cycle on a valid/ready port.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   in_valid/in_*         per-lane commit payload, lane i at [(i+1)*W-1 -: W]
//   in_trap, in_cause     trap/interrupt taken this cycle and its cause
//   stall                 registered backpressure to the commit stage
//   out_valid/out_ready   head handshake; out_* head fields, zero when empty
//   count                 occupied entries; overflow sticky drop flag
module cosim_commit_queue #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned INST_LEN     = 32,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_trap,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         stall,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_is_trap,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic [XLEN-1:0]              out_cause,
  output logic [INST_LEN-1:0]          out_inst,
  output logic                         out_check,
  output logic [31:0]                  out_seq,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned MARGIN = 2 * (COMMIT_WIDTH + 1);

  typedef struct packed {
    logic                is_trap;
    logic                check;
    logic [31:0]         seq;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     wdata;
    logic [XLEN-1:0]     mstatus;
    logic [XLEN-1:0]     cause;
    logic [INST_LEN-1:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [31:0]     seq;

  logic [CW-1:0]   lane_off [COMMIT_WIDTH];
  logic [AW-1:0]   wr_idx   [COMMIT_WIDTH];
  entry_t          lane_e   [COMMIT_WIDTH];
  entry_t          trap_e;
  logic [AW-1:0]   trap_idx;
  logic [CW-1:0]   k;
  logic [CW-1:0]   n;
  logic [CW-1:0]   free;
  logic [CW-1:0]   count_next;
  logic            accept;
  logic            deq;

  // Compaction: each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    k = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_off[i]       = k;
      wr_idx[i]         = tail + AW'(k);
      lane_e[i]         = '0;
      lane_e[i].check   = in_check[i];
      lane_e[i].seq     = seq + 32'(k);
      lane_e[i].pc      = in_pc[i*XLEN +: XLEN];
      lane_e[i].wdata   = in_wdata[i*XLEN +: XLEN];
      lane_e[i].mstatus = in_mstatus[i*XLEN +: XLEN];
      lane_e[i].inst    = in_inst[i*INST_LEN +: INST_LEN];
      if (in_valid[i]) k = k + CW'(1);
    end
    // Trap follows the commits and carries the seq the next commit would get.
    trap_e         = '0;
    trap_e.is_trap = 1'b1;
    trap_e.cause   = in_cause;
    trap_e.seq     = seq + 32'(k);
    trap_idx       = tail + AW'(k);
    n              = k + CW'(in_trap);
    // Freed-this-cycle space is not counted, so free uses the current count.
    free           = CW'(DEPTH) - count;
    accept         = (n <= free);
    deq            = out_valid && out_ready;
    count_next     = count + (accept ? n : CW'(0)) - CW'(deq);
  end

  // Queue storage; not reset, empty entries are masked at the output.
  always_ff @(posedge clock) begin
    if (reset && accept) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) mem[wr_idx[i]] <= lane_e[i];
      end
      if (in_trap) mem[trap_idx] <= trap_e;
    end
  end

  // Pointers, occupancy, sequence counter and status flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      seq       <= '0;
      stall     <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        tail <= tail + AW'(n);
        seq  <= seq + 32'(k);
      end else begin
        overflow <= 1'b1;
      end
      if (deq) head <= head + AW'(1);
      count     <= count_next;
      out_valid <= (count_next != '0);
      stall     <= (CW'(DEPTH) - count_next) < CW'(MARGIN);
    end
  end

  // Head fields, forced to zero while the queue is empty.
  always_comb begin
    out_is_trap = 1'b0;
    out_pc      = '0;
    out_wdata   = '0;
    out_mstatus = '0;
    out_cause   = '0;
    out_inst    = '0;
    out_check   = 1'b0;
    out_seq     = '0;
    if (out_valid) begin
      out_is_trap = mem[head].is_trap;
      out_pc      = mem[head].pc;
      out_wdata   = mem[head].wdata;
      out_mstatus = mem[head].mstatus;
      out_cause   = mem[head].cause;
      out_inst    = mem[head].inst;
      out_check   = mem[head].check;
      out_seq     = mem[head].seq;
    end
  end

endmodule

// File: tb/tb_cosim_commit_queue.sv
module tb_cosim_commit_queue;
  localparam int W     = 2;
  localparam int XL    = 64;
  localparam int IL    = 32;
  localparam int DEPTH = 16;

  typedef struct {
    logic        is_trap;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mstatus;
    logic [63:0] cause;
    logic        check;
    logic [31:0] seq;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [W-1:0]    in_valid = '0;
  logic [XL*W-1:0] in_pc = '0;
  logic [IL*W-1:0] in_inst = '0;
  logic [XL*W-1:0] in_wdata = '0;
  logic [XL*W-1:0] in_mstatus = '0;
  logic [W-1:0]    in_check = '0;
  logic            in_trap = 1'b0;
  logic [XL-1:0]   in_cause = '0;
  logic            stall, out_valid, out_is_trap, out_check, overflow;
  logic            out_ready = 1'b0;
  logic [XL-1:0]   out_pc, out_wdata, out_mstatus, out_cause;
  logic [IL-1:0]   out_inst;
  logic [31:0]     out_seq;
  logic [4:0]      count;

  cosim_commit_queue #(.COMMIT_WIDTH(W), .XLEN(XL), .INST_LEN(IL), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_wdata(in_wdata), .in_mstatus(in_mstatus),
    .in_check(in_check), .in_trap(in_trap), .in_cause(in_cause),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_trap(out_is_trap), .out_pc(out_pc), .out_wdata(out_wdata),
    .out_mstatus(out_mstatus), .out_cause(out_cause), .out_inst(out_inst),
    .out_check(out_check), .out_seq(out_seq), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  int          mcount = 0;
  logic [31:0] mseq = '0;
  logic        movf = 1'b0;
  logic [63:0] lane_pc [W];
  logic [31:0] lane_inst [W];
  logic [63:0] lane_wdata [W];
  logic [63:0] lane_mst [W];
  logic        lane_chk [W];
  logic [63:0] cause_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic new_lanes();
    for (int i = 0; i < W; i++) begin
      lane_pc[i]    = {$urandom, $urandom};
      lane_inst[i]  = $urandom;
      lane_wdata[i] = {$urandom, $urandom};
      lane_mst[i]   = {$urandom, $urandom};
      lane_chk[i]   = 1'($urandom_range(0, 1));
    end
    cause_v = {$urandom, $urandom};
  endtask

  task automatic check_status();
    check("count", 64'(count), 64'(mcount));
    check("stall", 64'(stall), 64'((DEPTH - mcount) < 2 * (W + 1)));
    check("overflow", 64'(overflow), 64'(movf));
  endtask

  // One clock: drive inputs, score any dequeue, update the model, step the edge.
  task automatic cycle(input logic [W-1:0] vld, input logic trap, input logic rdy);
    exp_t e;
    int   kk, nn;
    logic dq;
    in_valid  = vld;
    in_trap   = trap;
    out_ready = rdy;
    in_cause  = cause_v;
    for (int i = 0; i < W; i++) begin
      in_pc[i*XL +: XL]      = lane_pc[i];
      in_inst[i*IL +: IL]    = lane_inst[i];
      in_wdata[i*XL +: XL]   = lane_wdata[i];
      in_mstatus[i*XL +: XL] = lane_mst[i];
      in_check[i]            = lane_chk[i];
    end
    check("out_valid", 64'(out_valid), 64'(mcount != 0));
    dq = (mcount != 0) && rdy;
    if (dq && sb.size() > 0) begin
      e = sb.pop_front();
      check("is_trap", 64'(out_is_trap), 64'(e.is_trap));
      check("pc", out_pc, e.pc);
      check("inst", 64'(out_inst), 64'(e.inst));
      check("wdata", out_wdata, e.wdata);
      check("mstatus", out_mstatus, e.mstatus);
      check("cause", out_cause, e.cause);
      check("chk", 64'(out_check), 64'(e.check));
      check("seq", 64'(out_seq), 64'(e.seq));
    end
    kk = 0;
    for (int i = 0; i < W; i++) kk += int'(vld[i]);
    nn = kk + int'(trap);
    if (nn <= DEPTH - mcount) begin
      for (int i = 0; i < W; i++) begin
        if (vld[i]) begin
          e = '{1'b0, lane_pc[i], lane_inst[i], lane_wdata[i], lane_mst[i], 64'h0, lane_chk[i], mseq};
          sb.push_back(e);
          mseq++;
        end
      end
      if (trap) begin
        e = '{1'b1, 64'h0, 32'h0, 64'h0, 64'h0, cause_v, 1'b0, mseq};
        sb.push_back(e);
      end
      mcount += nn;
    end else begin
      movf = 1'b1;
    end
    if (dq) mcount--;
    @(posedge clock);
    #1;
    in_valid = '0;
    in_trap  = 1'b0;
    check_status();
    new_lanes();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = '0;
    in_trap   = 1'b0;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    mcount = 0;
    mseq   = '0;
    movf   = 1'b0;
    sb.delete();
    check_status();
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_seq", 64'(out_seq), 64'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle('0, 1'b0, 1'b1);
  endtask

  initial begin
    new_lanes();
    @(posedge clock);
    #1;
    do_reset();

    // Single lane0 commit, visible the cycle after enqueue.
    lane_pc[0]   = 64'h8000_0000;
    lane_inst[0] = 32'h0000_0013;
    cycle(2'b01, 1'b0, 1'b0);
    check("t1_valid", 64'(out_valid), 64'h1);
    check("t1_pc", out_pc, 64'h8000_0000);
    check("t1_seq", 64'(out_seq), 64'h0);
    check("t1_count", 64'(count), 64'h1);
    cycle('0, 1'b0, 1'b1);
    check("t1_empty", 64'(count), 64'h0);

    // Two lanes plus a trap, then a commit that must reuse the trap's seq.
    do_reset();
    cause_v = 64'h8000_0000_0000_0007;
    cycle(2'b11, 1'b1, 1'b0);
    check("t2_count", 64'(count), 64'h3);
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    check("t2_trap_head", 64'(out_is_trap), 64'h1);
    check("t2_trap_seq", 64'(out_seq), 64'h2);
    check("t2_trap_cause", out_cause, 64'h8000_0000_0000_0007);
    cycle(2'b01, 1'b0, 1'b1);
    check("t2_next_seq", 64'(out_seq), 64'h2);
    drain();

    // Lane1 only: compacted into a single entry.
    do_reset();
    cycle(2'b10, 1'b0, 1'b0);
    check("t3_count", 64'(count), 64'h1);
    drain();

    // Fill to the stall threshold, overflow when nearly full, then fill exactly.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(2'b11, 1'b1, 1'b0);
    check("t4_stall12", 64'(stall), 64'h1);
    cycle(2'b01, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    check("t4_count15", 64'(count), 64'd15);
    cycle(2'b11, 1'b1, 1'b0);
    check("t4_ovf", 64'(overflow), 64'h1);
    check("t4_count_kept", 64'(count), 64'd15);
    cycle(2'b01, 1'b0, 1'b0);
    check("t4_full", 64'(count), 64'd16);
    cycle(2'b01, 1'b0, 1'b1);
    check("t4_full_deq", 64'(count), 64'd15);
    drain();

    // Reset with entries present and overflow set.
    cycle(2'b11, 1'b1, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    check("t5_count5", 64'(count), 64'd5);
    do_reset();
    cycle(2'b01, 1'b0, 1'b0);
    check("t5_seq0", 64'(out_seq), 64'h0);
    drain();

    // Sustained one-in/one-out across pointer wrap.
    do_reset();
    cycle(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(2'b01, 1'b0, 1'b1);
    check("t6_count1", 64'(count), 64'h1);
    drain();
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cosim_commit_queue.md
# cosim_commit_queue

Parametrised commit-trace buffer between the core's commit stage and the co-simulation checker. Each cycle it accepts up to COMMIT_WIDTH retired instructions plus one trap/interrupt event, packs them in program order into a circular queue, and presents them one entry per cycle on a valid/ready port. It generalises the single-cycle, fixed-width commit hand-off with buffering, backpressure, in-order trap tagging, sequence numbering and overflow detection.

## Interface
- COMMIT_WIDTH, 2: commit lanes per cycle, 1..8.
- XLEN, 64: data/address width.
- INST_LEN, 32: instruction word width.
- DEPTH, 16: queue entries; power of two, at least 2*(COMMIT_WIDTH+1).
- clock  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  COMMIT_WIDTH  per-lane commit valid.
- in_pc  in  XLEN*COMMIT_WIDTH  lane i in bits [(i+1)*XLEN-1 -: XLEN].
- in_inst  in  INST_LEN*COMMIT_WIDTH  instruction words, same packing.
- in_wdata  in  XLEN*COMMIT_WIDTH  writeback data.
- in_mstatus  in  XLEN*COMMIT_WIDTH  mstatus after commit.
- in_check  in  COMMIT_WIDTH  compare-wdata flag per lane.
- in_trap  in  1  trap/interrupt taken this cycle.
- in_cause  in  XLEN  trap cause.
- stall  out  1  registered backpressure to the commit stage.
- out_valid  out  1  head entry present.
- out_ready  in  1  checker accepts head.
- out_is_trap  out  1  head is a trap entry.
- out_pc, out_wdata, out_mstatus, out_cause  out  XLEN each  head fields.
- out_inst  out  INST_LEN  head instruction.
- out_check  out  1  head check flag.
- out_seq  out  32  commit sequence number of the head.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky: an input cycle was dropped.

## Operation
- k = popcount(in_valid); n = k + in_trap.
- Valid lanes are written in ascending lane order to tail, tail+1, …, tail+k-1. Gaps are compacted. The trap entry, if present, goes to tail+k. tail advances by n modulo DEPTH.
- Commit entries store pc, inst, wdata, mstatus, check, and seq. Trap entries store cause, is_trap=1, and seq; their other fields are 0.
- seq counter (32 bits, wraps): a commit entry takes the current value and the counter then advances by 1 per commit entry. A trap entry takes the value the next commit will receive.
- Dequeue occurs when out_valid && out_ready; head advances by 1.
- free = DEPTH - count, using the pre-update count. Space freed by this cycle's dequeue is not usable in the same cycle.
- If n > free, all of this cycle's inputs are dropped: nothing is written, tail and seq are unchanged, and overflow is set to 1 until reset. A dequeue in the same cycle still proceeds.
- count_next = count + (accepted ? n : 0) - deq.
- stall register is loaded with (DEPTH - count_next) < 2*(COMMIT_WIDTH+1).
- out_valid = (count != 0). It is first-word-fall-through from registered state.
- All out_* data fields are forced to 0 when out_valid = 0.

## Timing
- Reset (reset = 0 at a clock edge) sets head, tail, count, and seq to 0, and stall, out_valid, and overflow to 0. All data outputs read 0. Queue memory is not reset.
- Reset takes priority over simultaneous enqueue or dequeue. A reset mid-operation discards all entries.
- Latency: an entry enqueued at edge N is visible on out_* after edge N and can be dequeued at edge N+1. Back-to-back dequeue runs at 1 entry per cycle.
- stall reflects occupancy after edge N and is visible one cycle later. The 2*(COMMIT_WIDTH+1) margin absorbs one extra full input cycle issued before the core reacts.
- Head, tail, and the memory index wrap modulo DEPTH. count reaches DEPTH exactly when the queue is full.
- Enqueue and dequeue in the same cycle with count = 0: the new entry is not bypassed. out_valid rises next cycle.
- Enqueue at count = DEPTH with a simultaneous dequeue (n ≥ 1): the input is dropped and overflow is set.

## Test plan
- Reset, then lane0 commit with pc=0x80000000, inst=0x00000013 -> one cycle later out_valid=1, out_pc=0x80000000, out_seq=0, count=1. Dequeue -> count=0.
- COMMIT_WIDTH=2: both lanes valid plus in_trap with cause=0x8000000000000007 in one cycle -> three entries in order lane0 (seq 0), lane1 (seq 1), trap (out_is_trap=1, seq 2). A following commit gets seq 2.
- in_valid=2'b10 only -> single entry carrying lane1 data with seq 0. No empty entry is created.
- DEPTH=16, out_ready=0, 3 entries/cycle -> after the edge where count reaches 12, stall=1 one cycle later. With count=15, push 3 -> overflow=1 and count stays 15. Push 1 -> accepted, count=16.
- Sustained 1-in/1-out for 40 cycles with one initial entry -> out_seq runs 0..39 in order across pointer wrap. count stays 1. overflow stays 0.
- Reset asserted with count=5 and overflow=1 -> next cycle count=0, out_valid=0, overflow=0, stall=0. A new enqueue afterwards gets seq 0.
